// File: rtl/seed_request_scheduler.sv
// rtl/seed_request_scheduler.sv - round-robin seed issue scheduler with entropy accumulation windows
module seed_request_scheduler #(
  parameter int unsigned ACCUM_CYCLES = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] gen_seed1,
  input  logic [127:0] gen_seed2,
  input  logic         req0,
  input  logic         req1,
  output logic         gnt0,
  output logic         gnt1,
  output logic [255:0] seed_out,
  output logic         seed_valid,
  output logic [255:0] seedloop,
  output logic         ready,
  output logic [15:0]  issue_cnt
);

  typedef enum logic [1:0] {
    WARMUP   = 2'd0,
    READY    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam logic [255:0] SEEDLOOP_RST =
    256'h3F72C91E5A6BD4FA8937CE1204B1DA6E_A8B2F3C01D9E6A3774CCE0B83F91AD24;
  localparam logic [7:0] LAST_CNT = 8'(ACCUM_CYCLES - 1);

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           prio1_q, prio1_d;   // 1: consumer 1 wins a tie
  logic           gnt0_q, gnt0_d;
  logic           gnt1_q, gnt1_d;
  logic           valid_q, valid_d;
  logic [255:0]   seed_out_q, seed_out_d;
  logic [255:0]   seedloop_q, seedloop_d;
  logic [15:0]    issue_cnt_q, issue_cnt_d;
  logic           sel1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio1_d     = prio1_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    valid_d     = 1'b0;
    seed_out_d  = seed_out_q;
    seedloop_d  = seedloop_q;
    issue_cnt_d = issue_cnt_q;
    sel1        = 1'b0;
    case (state_q)
      WARMUP, COOLDOWN: begin
        if (cnt_q == LAST_CNT) begin
          state_d = READY;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      READY: begin
        if (req0 | req1) begin
          // A lone requester always wins; the pointer only breaks ties.
          sel1        = req1 & (~req0 | prio1_q);
          gnt1_d      = sel1;
          gnt0_d      = ~sel1;
          prio1_d     = ~sel1;
          valid_d     = 1'b1;
          seed_out_d  = {gen_seed1, gen_seed2};
          seedloop_d  = {gen_seed2, gen_seed1} ^ {240'b0, issue_cnt_q};
          issue_cnt_d = issue_cnt_q + 16'd1;
          state_d     = COOLDOWN;
          cnt_d       = 8'd0;
        end
      end
      default: begin
        state_d = WARMUP;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WARMUP;
      cnt_q       <= 8'd0;
      prio1_q     <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      valid_q     <= 1'b0;
      seed_out_q  <= 256'd0;
      seedloop_q  <= SEEDLOOP_RST;
      issue_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio1_q     <= prio1_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      valid_q     <= valid_d;
      seed_out_q  <= seed_out_d;
      seedloop_q  <= seedloop_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign seed_valid = valid_q;
  assign seed_out   = seed_out_q;
  assign seedloop   = seedloop_q;
  assign issue_cnt  = issue_cnt_q;
  assign ready      = (state_q == READY);

endmodule

// File: doc/seed_request_scheduler.md
SEED_REQUEST_SCHEDULER -- requirements
Module: seed_request_scheduler

Interface
REQ-001 The block SHALL have parameter ACCUM_CYCLES, default 8, meaning entropy-accumulation cycles required before each seed issue (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 The block SHALL have port gen_seed1, input, 128, seed1 from the entropy seed generator.
REQ-005 The block SHALL have port gen_seed2, input, 128, seed2 from the entropy seed generator.
REQ-006 The block SHALL have port req0, input, 1, seed request from consumer 0, held high until granted.
REQ-007 The block SHALL have port req1, input, 1, seed request from consumer 1, held high until granted.
REQ-008 The block SHALL have port gnt0, output, 1, one-cycle grant pulse to consumer 0.
REQ-009 The block SHALL have port gnt1, output, 1, one-cycle grant pulse to consumer 1.
REQ-010 The block SHALL have port seed_out, output, 256, issued seed {seed1,seed2}, valid when seed_valid=1.
REQ-011 The block SHALL have port seed_valid, output, 1, one-cycle pulse coincident with gnt0|gnt1.
REQ-012 The block SHALL have port seedloop, output, 256, feedback/configuration value driven to the generator's seedloop input.
REQ-013 The block SHALL have port ready, output, 1, high while in state READY.
REQ-014 The block SHALL have port issue_cnt, output, 16, count of seeds issued since reset.

Function
REQ-015 FSM states SHALL be WARMUP, READY, COOLDOWN; reset state is WARMUP.
REQ-016 An 8-bit accumulation counter SHALL clear on entry to WARMUP/COOLDOWN and increment each cycle in those states.
REQ-017 WARMUP and COOLDOWN SHALL transition to READY on the edge where the counter equals ACCUM_CYCLES-1, i.e. exactly ACCUM_CYCLES cycles spent in that state.
REQ-018 In READY with req0|req1 sampled high, the next edge SHALL: assert the selected gnt for one cycle, assert seed_valid, load seed_out <= {gen_seed1,gen_seed2} as sampled in that READY cycle, and go to COOLDOWN.
REQ-019 Grant latency SHALL be 1 cycle from a request sampled in READY; requests in WARMUP/COOLDOWN SHALL be held pending, not granted.
REQ-020 In READY with no request, the block SHALL remain in READY indefinitely.
REQ-021 Arbitration SHALL be round-robin: with both requests high, grant the consumer not granted last; after reset, consumer 0 has priority.
REQ-022 With a single request high, that consumer SHALL be granted regardless of round-robin pointer; the pointer SHALL update only on a grant.
REQ-023 gnt0 and gnt1 SHALL never be high in the same cycle; at most one grant per READY->COOLDOWN pass.
REQ-024 A request deasserted before being sampled in READY SHALL receive no grant and cause no state change.
REQ-025 seed_out SHALL hold its value between grants; seed_valid and gnt SHALL be low in every cycle without a grant.
REQ-026 On each grant, seedloop SHALL load {gen_seed2,gen_seed1} XOR {240'b0, issue_cnt} (issue_cnt pre-increment value); otherwise it SHALL hold.
REQ-027 issue_cnt SHALL increment by 1 on each grant and wrap 16'hFFFF -> 16'h0000.
REQ-028 ready SHALL be combinationally equal to (state==READY).

Reset
REQ-029 With rst_n low at a clock edge, the block SHALL set state=WARMUP, counter=0, gnt0=gnt1=0, seed_valid=0, seed_out=0, issue_cnt=0, round-robin pointer to consumer 0, seedloop=256'h3F72C91E5A6BD4FA8937CE1204B1DA6E_A8B2F3C01D9E6A3774CCE0B83F91AD24.
REQ-030 Reset asserted mid-operation, including in the grant cycle, SHALL discard any pending grant; no gnt or seed_valid SHALL appear on the following edge.
REQ-031 After rst_n rises, the first grant SHALL be possible no earlier than ACCUM_CYCLES+1 edges later.

Verification
REQ-032 Warmup: ACCUM_CYCLES=8, req0 high from reset release -> ready rises after 8 cycles, gnt0 pulses next cycle, issue_cnt=1.
REQ-033 Contention: req0=req1=1 held -> grants alternate gnt0, gnt1, gnt0, each 9 cycles apart (8 COOLDOWN + 1 READY).
REQ-034 Seed capture: gen_seed1=128'h1, gen_seed2=128'h2 in the READY cycle -> seed_out=256'h{0..01,0..02}; seedloop={0..02,0..01} XOR 0.
REQ-035 Idle hold: no requests for 100 cycles after warmup -> ready stays 1, no gnt; req1 then asserted -> gnt1 next cycle.
REQ-036 Wrap: preload issue_cnt to 16'hFFFF via 65535 grants, or force it -> next grant yields issue_cnt=0.
REQ-037 Mid-op reset: rst_n low in the READY cycle with req0=1 -> no gnt0, outputs at reset values, warmup restarts.
